// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single data-memory port (15-bit word address, 16-bit data)
// between the instruction-fetch unit (port f, read only) and the load/store
// unit (port d, read or write). One access is in flight at a time. Ties go
// round-robin, or always to port d when D_PRIORITY=1. Reads return data with
// a one-cycle rvalid pulse RD_LAT edges after the accept edge. Stores complete
// in the accept cycle (m_wen pulse) and produce no rvalid.
//
// Parameters:
//   RD_LAT     rising edges after the accept edge at which m_rdata is sampled (>=1)
//   D_PRIORITY 1: port d wins every tie; 0: round-robin
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   f_req, f_addr                 fetch read request / byte address (bit 0 ignored)
//   f_ack, f_rvalid, f_rdata      fetch accept pulse, data-valid pulse, read data
//   d_req, d_we, d_addr, d_wdata  load/store request, 1=store, byte address, store data
//   d_ack, d_rvalid, d_rdata      load/store accept pulse, data-valid pulse, load data
//   m_raddr, m_rdata              memory read word address / read data
//   m_wen, m_waddr, m_wdata       memory write enable / word address / write data
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned RD_LAT     = 2,
  parameter bit          D_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_ack,
  output logic        f_rvalid,
  output logic [15:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  output logic [14:0] m_raddr,
  input  logic [15:0] m_rdata,
  output logic        m_wen,
  output logic [14:0] m_waddr,
  output logic [15:0] m_wdata
);

  localparam int unsigned CW = $clog2(RD_LAT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;     // edges left until m_rdata is sampled
  logic          last_d, last_d_nxt;   // 1: port d was granted most recently
  logic          owner_d, owner_d_nxt; // 1: the in-flight read belongs to port d

  logic          f_ack_nxt, f_rvalid_nxt, d_ack_nxt, d_rvalid_nxt, m_wen_nxt;
  logic [15:0]   f_rdata_nxt, d_rdata_nxt, m_wdata_nxt;
  logic [14:0]   m_raddr_nxt, m_waddr_nxt;

  logic          f_elig, d_elig, pick_d;
  logic          unused_addr_lsb;

  // Byte addresses are word aligned; bit 0 carries no information.
  assign unused_addr_lsb = f_addr[0] ^ d_addr[0];

  // A port whose ack is high this cycle is still showing the request that was
  // just accepted, so it must not be taken a second time.
  assign f_elig = f_req & ~f_ack;
  assign d_elig = d_req & ~d_ack;

  // d wins when alone, under fixed priority, or when f was granted last.
  assign pick_d = d_elig & (~f_elig | D_PRIORITY | ~last_d);

  // NOTE: every variable assigned here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    last_d_nxt   = last_d;
    owner_d_nxt  = owner_d;
    f_ack_nxt    = 1'b0;
    d_ack_nxt    = 1'b0;
    f_rvalid_nxt = 1'b0;
    d_rvalid_nxt = 1'b0;
    m_wen_nxt    = 1'b0;
    f_rdata_nxt  = f_rdata;
    d_rdata_nxt  = d_rdata;
    m_raddr_nxt  = m_raddr;
    m_waddr_nxt  = m_waddr;
    m_wdata_nxt  = m_wdata;

    case (state)
      IDLE: begin
        if (f_elig | d_elig) begin
          last_d_nxt = pick_d;
          if (pick_d && d_we) begin
            // Store finishes in the accept cycle; the arbiter stays free.
            d_ack_nxt   = 1'b1;
            m_wen_nxt   = 1'b1;
            m_waddr_nxt = d_addr[15:1];
            m_wdata_nxt = d_wdata;
          end else begin
            m_raddr_nxt = pick_d ? d_addr[15:1] : f_addr[15:1];
            f_ack_nxt   = ~pick_d;
            d_ack_nxt   = pick_d;
            owner_d_nxt = pick_d;
            count_nxt   = CW'(RD_LAT);
            state_nxt   = WAIT;
          end
        end
      end

      WAIT: begin
        if (count == CW'(1)) begin
          state_nxt = IDLE;
          if (owner_d) begin
            d_rvalid_nxt = 1'b1;
            d_rdata_nxt  = m_rdata;
          end else begin
            f_rvalid_nxt = 1'b1;
            f_rdata_nxt  = m_rdata;
          end
        end else begin
          count_nxt = count - CW'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      last_d   <= 1'b0;  // f counts as granted last, so d wins the first tie
      owner_d  <= 1'b0;
      f_ack    <= 1'b0;
      d_ack    <= 1'b0;
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      m_wen    <= 1'b0;
      f_rdata  <= '0;
      d_rdata  <= '0;
      m_raddr  <= '0;
      m_waddr  <= '0;
      m_wdata  <= '0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      last_d   <= last_d_nxt;
      owner_d  <= owner_d_nxt;
      f_ack    <= f_ack_nxt;
      d_ack    <= d_ack_nxt;
      f_rvalid <= f_rvalid_nxt;
      d_rvalid <= d_rvalid_nxt;
      m_wen    <= m_wen_nxt;
      f_rdata  <= f_rdata_nxt;
      d_rdata  <= d_rdata_nxt;
      m_raddr  <= m_raddr_nxt;
      m_waddr  <= m_waddr_nxt;
      m_wdata  <= m_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiters side by side: instance 0 round-robin, instance 1 d-priority.
// Each has its own memory, its own request queues and requesters that hold
// req until ack and present the next queued request in the ack cycle.
// A transaction-level model (cycle stamps + reference memory) predicts every
// output; a compare process checks them on every falling edge. Directed
// scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int unsigned RD_LAT = 2;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;

  logic [1:0]  f_req, f_ack, f_rvalid, d_req, d_we, d_ack, d_rvalid, m_wen;
  logic [15:0] f_addr [2];
  logic [15:0] f_rdata [2];
  logic [15:0] d_addr [2];
  logic [15:0] d_wdata [2];
  logic [15:0] d_rdata [2];
  logic [15:0] m_rdata [2];
  logic [15:0] m_wdata [2];
  logic [14:0] m_raddr [2];
  logic [14:0] m_waddr [2];

  logic [15:0] mem0 [32768];
  logic [15:0] mem1 [32768];
  logic [15:0] ref0 [32768];
  logic [15:0] ref1 [32768];

  req_t fq0[$], fq1[$], dq0[$], dq1[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] glog_v [2];
  int          glog_n [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .RD_LAT    (RD_LAT),
      .D_PRIORITY(g == 1)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .f_req   (f_req[g]),
      .f_addr  (f_addr[g]),
      .f_ack   (f_ack[g]),
      .f_rvalid(f_rvalid[g]),
      .f_rdata (f_rdata[g]),
      .d_req   (d_req[g]),
      .d_we    (d_we[g]),
      .d_addr  (d_addr[g]),
      .d_wdata (d_wdata[g]),
      .d_ack   (d_ack[g]),
      .d_rvalid(d_rvalid[g]),
      .d_rdata (d_rdata[g]),
      .m_raddr (m_raddr[g]),
      .m_rdata (m_rdata[g]),
      .m_wen   (m_wen[g]),
      .m_waddr (m_waddr[g]),
      .m_wdata (m_wdata[g])
    );
  end

  // Memory: combinational read, write on rising edge.
  assign m_rdata[0] = mem0[m_raddr[0]];
  assign m_rdata[1] = mem1[m_raddr[1]];
  always @(posedge clk) begin
    if (m_wen[0]) mem0[m_waddr[0]] <= m_wdata[0];
    if (m_wen[1]) mem1[m_waddr[1]] <= m_wdata[1];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: a read accepted at edge number N delivers at edge N+RD_LAT; while a
  // read is outstanding nothing is accepted. Data comes from the reference
  // memory, which is updated by accepted stores.
  // ---------------------------------------------------------------------------
  logic [1:0]  e_f_ack, e_d_ack, e_f_rv, e_d_rv, e_wen, busy, owner_d, last_d;
  logic [14:0] e_raddr [2];
  logic [14:0] e_waddr [2];
  logic [15:0] e_f_rdata [2];
  logic [15:0] e_d_rdata [2];
  logic [15:0] e_wdata [2];
  logic [15:0] pend_data [2];
  int unsigned cyc [2];
  int unsigned due [2];

  always @(posedge clk or negedge rst_n) begin
    int unsigned now;
    logic        fe, de, take_d;
    logic [15:0] a;
    if (!rst_n) begin
      e_f_ack <= '0; e_d_ack <= '0; e_f_rv <= '0; e_d_rv <= '0; e_wen <= '0;
      busy <= '0; owner_d <= '0; last_d <= '0;
      for (int i = 0; i < 2; i++) begin
        e_raddr[i] <= '0; e_waddr[i] <= '0; e_wdata[i] <= '0;
        e_f_rdata[i] <= '0; e_d_rdata[i] <= '0;
        cyc[i] <= 0; due[i] <= 0; pend_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        now = cyc[i] + 1;
        cyc[i] <= now;
        e_f_ack[i] <= 1'b0; e_d_ack[i] <= 1'b0;
        e_f_rv[i]  <= 1'b0; e_d_rv[i]  <= 1'b0; e_wen[i] <= 1'b0;
        if (busy[i]) begin
          if (now == due[i]) begin
            busy[i] <= 1'b0;
            if (owner_d[i]) begin e_d_rv[i] <= 1'b1; e_d_rdata[i] <= pend_data[i]; end
            else            begin e_f_rv[i] <= 1'b1; e_f_rdata[i] <= pend_data[i]; end
          end
        end else begin
          fe = f_req[i] && !e_f_ack[i];
          de = d_req[i] && !e_d_ack[i];
          take_d = de && (!fe || (i == 1) || !last_d[i]);
          if (fe || de) begin
            last_d[i] <= take_d;
            if (take_d && d_we[i]) begin
              e_d_ack[i] <= 1'b1;
              e_wen[i]   <= 1'b1;
              e_waddr[i] <= d_addr[i][15:1];
              e_wdata[i] <= d_wdata[i];
              if (i == 0) ref0[d_addr[i][15:1]] <= d_wdata[i];
              else        ref1[d_addr[i][15:1]] <= d_wdata[i];
            end else begin
              a = take_d ? d_addr[i] : f_addr[i];
              e_raddr[i] <= a[15:1];
              if (take_d) e_d_ack[i] <= 1'b1;
              else        e_f_ack[i] <= 1'b1;
              busy[i]      <= 1'b1;
              owner_d[i]   <= take_d;
              due[i]       <= now + RD_LAT;
              pend_data[i] <= (i == 0) ? ref0[a[15:1]] : ref1[a[15:1]];
            end
          end
        end
      end
    end
  end

  // Compare every output on every falling edge; also log grant order.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("f_ack[%0d]", i),    f_ack[i],    e_f_ack[i]);
      check($sformatf("d_ack[%0d]", i),    d_ack[i],    e_d_ack[i]);
      check($sformatf("f_rvalid[%0d]", i), f_rvalid[i], e_f_rv[i]);
      check($sformatf("d_rvalid[%0d]", i), d_rvalid[i], e_d_rv[i]);
      check($sformatf("f_rdata[%0d]", i),  f_rdata[i],  e_f_rdata[i]);
      check($sformatf("d_rdata[%0d]", i),  d_rdata[i],  e_d_rdata[i]);
      check($sformatf("m_raddr[%0d]", i),  m_raddr[i],  e_raddr[i]);
      check($sformatf("m_wen[%0d]", i),    m_wen[i],    e_wen[i]);
      check($sformatf("m_waddr[%0d]", i),  m_waddr[i],  e_waddr[i]);
      check($sformatf("m_wdata[%0d]", i),  m_wdata[i],  e_wdata[i]);
      if (f_ack[i] === 1'b1) begin glog_v[i] = glog_v[i] << 1;          glog_n[i]++; end
      if (d_ack[i] === 1'b1) begin glog_v[i] = (glog_v[i] << 1) | 16'd1; glog_n[i]++; end
    end
  end

  // ---------------------------------------------------------------------------
  // Requesters
  // ---------------------------------------------------------------------------
  function automatic bit pop(input int i, input bit is_d, output req_t r);
    r = '0;
    if (!is_d && i == 0 && fq0.size() > 0) begin r = fq0.pop_front(); return 1'b1; end
    if (!is_d && i == 1 && fq1.size() > 0) begin r = fq1.pop_front(); return 1'b1; end
    if ( is_d && i == 0 && dq0.size() > 0) begin r = dq0.pop_front(); return 1'b1; end
    if ( is_d && i == 1 && dq1.size() > 0) begin r = dq1.pop_front(); return 1'b1; end
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    req_t r;
    for (int i = 0; i < 2; i++) begin
      if (f_req[i] && f_ack[i] === 1'b1) f_req[i] = 1'b0;
      if (!f_req[i] && pop(i, 1'b0, r)) begin
        f_req[i]  = 1'b1;
        f_addr[i] = r.addr;
      end
      if (d_req[i] && d_ack[i] === 1'b1) d_req[i] = 1'b0;
      if (!d_req[i] && pop(i, 1'b1, r)) begin
        d_req[i]   = 1'b1;
        d_we[i]    = r.we;
        d_addr[i]  = r.addr;
        d_wdata[i] = r.wdata;
      end
    end
  end

  task automatic push_f(input logic [15:0] a);
    req_t r;
    r = '{we: 1'b0, addr: a, wdata: 16'h0};
    fq0.push_back(r);
    fq1.push_back(r);
  endtask

  task automatic push_d(input logic we, input logic [15:0] a, input logic [15:0] wd);
    req_t r;
    r = '{we: we, addr: a, wdata: wd};
    dq0.push_back(r);
    dq1.push_back(r);
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (fq0.size() == 0 && fq1.size() == 0 && dq0.size() == 0 && dq1.size() == 0 &&
          f_req == 2'b00 && d_req == 2'b00 && busy == 2'b00 &&
          f_ack == 2'b00 && d_ack == 2'b00) begin
        done = 1'b1;
        break;
      end
    end
    check("drain", done, 1'b1);
  endtask

  // Waits on a falling edge until the chosen inst-0 output is high.
  task automatic wait_high(input int which, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if ((which == 0 && f_ack[0] === 1'b1) || (which == 1 && d_ack[0] === 1'b1) ||
          (which == 2 && f_rvalid[0] === 1'b1) || (which == 3 && d_rvalid[0] === 1'b1)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [15:0] init_word(input int w);
    return 16'(w * 257) ^ 16'h3C5A;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    bit ok;
    int n;
    f_req = '0; d_req = '0; d_we = '0;
    for (int i = 0; i < 2; i++) begin
      f_addr[i] = '0; d_addr[i] = '0; d_wdata[i] = '0;
      glog_v[i] = '0; glog_n[i] = 0;
    end
    for (int w = 0; w < 32768; w++) begin
      mem0[w] = init_word(w); mem1[w] = init_word(w);
      ref0[w] = init_word(w); ref1[w] = init_word(w);
    end
    mem0[2] = 16'h8123; mem1[2] = 16'h8123;
    ref0[2] = 16'h8123; ref1[2] = 16'h8123;

    // 1: single fetch read with latency 2
    push_f(16'h0004);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) check($sformatf("reset_raddr[%0d]", i), m_raddr[i], 15'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("s1_f_ack[%0d]", i), f_ack[i], 1'b1);
      check($sformatf("s1_raddr[%0d]", i), m_raddr[i], 15'h0002);
    end
    @(posedge clk); #1;
    check("s1_f_rvalid_early", f_rvalid[0], 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("s1_f_rvalid[%0d]", i), f_rvalid[i], 1'b1);
      check($sformatf("s1_f_rdata[%0d]", i),  f_rdata[i],  16'h8123);
    end
    @(posedge clk); #1;
    check("s1_f_rvalid_drop", f_rvalid[0], 1'b0);
    wait_drain(50);

    // 2: store then load of the same address
    push_d(1'b1, 16'h0010, 16'hBEEF);
    push_d(1'b0, 16'h0010, 16'h0000);
    wait_high(1, 50, ok);
    check("s2_store_ack_seen", ok, 1'b1);
    check("s2_m_wen",     m_wen[0],   1'b1);
    check("s2_m_waddr",   m_waddr[0], 15'h0008);
    check("s2_m_wdata",   m_wdata[0], 16'hBEEF);
    check("s2_no_rvalid", d_rvalid[0], 1'b0);
    @(negedge clk);
    wait_high(3, 50, ok);
    check("s2_load_rvalid_seen", ok, 1'b1);
    check("s2_load_rdata", d_rdata[0], 16'hBEEF);
    wait_drain(50);

    // 3/4: contention from reset; addresses include the wrap case FFFF
    rst_n = 1'b0;
    glog_v[0] = '0; glog_v[1] = '0; glog_n[0] = 0; glog_n[1] = 0;
    push_f(16'hFFFF); push_f(16'h0006);
    push_d(1'b0, 16'h0004, 16'h0); push_d(1'b0, 16'h0008, 16'h0); push_d(1'b0, 16'h000A, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_drain(200);
    check("s3_rr_grants_n",   glog_n[0], 5);
    check("s3_rr_order",      glog_v[0], 16'b10101);
    check("s4_prio_grants_n", glog_n[1], 5);
    check("s4_prio_order",    glog_v[1], 16'b11100);

    // 5: store accepted while a fetch waits; fetch follows on the next edge
    @(negedge clk);
    rst_n = 1'b0;
    push_d(1'b1, 16'h0100, 16'h1234);
    push_f(16'h0006);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("s5_d_ack[%0d]", i), d_ack[i], 1'b1);
      check($sformatf("s5_wen[%0d]", i),   m_wen[i], 1'b1);
      check($sformatf("s5_f_ack0[%0d]", i), f_ack[i], 1'b0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("s5_f_ack[%0d]", i), f_ack[i],   1'b1);
      check($sformatf("s5_wen0[%0d]", i),  m_wen[i],   1'b0);
      check($sformatf("s5_raddr[%0d]", i), m_raddr[i], 15'h0003);
    end
    wait_drain(50);

    // 6: reset in the middle of WAIT
    push_f(16'h0020);
    wait_high(0, 50, ok);
    check("s6_ack_seen", ok, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("s6_async_ctrl[%0d]", i),
            {f_ack[i], d_ack[i], f_rvalid[i], d_rvalid[i], m_wen[i]}, 5'b0);
      check($sformatf("s6_async_raddr[%0d]", i), m_raddr[i], 15'h0);
      check($sformatf("s6_async_waddr[%0d]", i), m_waddr[i], 15'h0);
      check($sformatf("s6_async_wdata[%0d]", i), m_wdata[i], 16'h0);
      check($sformatf("s6_async_frd[%0d]", i),   f_rdata[i], 16'h0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("s6_no_rvalid", {f_rvalid, d_rvalid}, 4'b0);
    end
    push_f(16'h0004);
    @(negedge clk);
    wait_high(0, 50, ok);
    check("s6_ack2_seen", ok, 1'b1);
    n = 0;
    while (f_rvalid[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("s6_latency", n, RD_LAT);
    check("s6_rdata", f_rdata[0], 16'h8123);
    wait_drain(50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory read/write port (15-bit word address, 16-bit data) between two requesters:
  - the instruction-fetch unit (port f, read only);
  - the load/store unit (port d, read or write).
- Sits between the CPU sequencer and the mem block.
- Serialises accesses, arbitrates ties round-robin (or data-first by parameter) and returns read data with a one-cycle valid pulse.

Parameters:
- RD_LAT, 2: rising edges after the accept edge at which m_rdata is sampled (>=1).
- D_PRIORITY, 0: 1 means port d always wins a tie; 0 means round-robin.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch read request, held until f_ack
- f_addr  in  16  fetch byte address, bit 0 ignored
- f_ack  out  1  one-cycle accept pulse, port f
- f_rvalid  out  1  one-cycle read-data-valid pulse, port f
- f_rdata  out  16  read data, port f, held until next f_rvalid
- d_req  in  1  load/store request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  16  load/store byte address, bit 0 ignored
- d_wdata  in  16  store data
- d_ack  out  1  one-cycle accept pulse, port d
- d_rvalid  out  1  one-cycle load-data-valid pulse, port d
- d_rdata  out  16  load data, held until next d_rvalid
- m_raddr  out  15  memory read word address
- m_rdata  in  16  memory read data
- m_wen  out  1  memory write enable
- m_waddr  out  15  memory write word address
- m_wdata  out  16  memory write data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all acks, rvalids and m_wen = 0.
  - m_raddr, m_waddr, m_wdata, f_rdata and d_rdata = 0.
  - Round-robin pointer set so port d wins the first tie.
  - Reset mid-read discards the access; no rvalid is ever produced for it.
- All outputs are registered.
- States: IDLE, WAIT.
- Eligibility, evaluated at each edge in IDLE:
  - A port is eligible if its req=1 and its ack is not currently 1.
  - The ack-cycle req is therefore never accepted twice.
  - Requesters drop req or present a new request in the ack cycle.
- Arbitration in IDLE:
  - One eligible port: it is granted.
  - Both eligible, D_PRIORITY=1: d is granted.
  - Both eligible, D_PRIORITY=0: the port not granted last is granted.
  - The pointer updates on every grant.
- Accepted read, edge E0:
  - m_raddr <= addr[15:1]; its ack=1 for one cycle.
  - State -> WAIT with count=RD_LAT.
- WAIT:
  - Count decrements each edge; m_raddr is held stable and m_wen=0.
  - At edge E0+RD_LAT, m_rdata is captured into the granted port's rdata, its rvalid=1 for one cycle, and state -> IDLE.
  - A new request can be accepted at E0+RD_LAT+1 at the earliest.
- Accepted store, edge E0:
  - m_waddr <= d_addr[15:1] and m_wdata <= d_wdata.
  - m_wen=1 for exactly one cycle; d_ack=1; state stays IDLE.
  - No d_rvalid is produced.
  - A new request can be accepted at E0+1 from the other port; the same port is ineligible at E0+1 because its ack is high.
- Requests arriving during WAIT are stalled, never dropped; they are evaluated on return to IDLE.
- At most one access is in flight. f and d rvalid are never high together. m_wen is never high in WAIT.
- Address wrap: byte 16'hFFFF maps to word 15'h7FFF; there are no range checks.

Test Plan:
- Reset then f_req=1, f_addr=16'h0004, mem word 2 = 16'h8123, RD_LAT=2 -> f_ack at cycle 1, m_raddr=15'h0002, f_rvalid one cycle at cycle 3 with f_rdata=16'h8123, then IDLE.
- d_req=1, d_we=1, d_addr=16'h0010, d_wdata=16'hBEEF -> d_ack and m_wen high the same single cycle with m_waddr=15'h0008 and m_wdata=16'hBEEF; no d_rvalid; a later load of 16'h0010 returns 16'hBEEF.
- f_req and d_req (reads) both held from reset, D_PRIORITY=0 -> grants alternate d, f, d, f; each rvalid goes only to its granted port; no double ack.
- Same contention with D_PRIORITY=1 and d_req held continuously with new addresses -> f never granted while d requests; f granted on the first IDLE edge after d_req drops.
- Store accepted while f_req is pending -> f accepted the very next edge; the m_wen cycle and the m_raddr update are not in WAIT together.
- rst_n pulsed low mid-WAIT -> outputs 0 asynchronously; no rvalid after release; the next request completes normally with the same latency.
